ram_port_arbiter: RTL

- Shares one 128x8 simple dual-port block RAM between two requesters.
- The RAM has a write port (we/addr_in/d) and a read port (addr_out/q). Its read address is registered and its read data is registered.
- Two independent round-robin arbiters, one per RAM port, grant at most one write and one read per cycle.
- Read data returns to the granted requester with a fixed latency and a per-requester valid strobe.

---
 rtl/ram_port_arbiter_if.sv | 41 ++++
 rtl/ram_port_arbiter.sv | 111 +++++++++++
 2 files changed

// File: rtl/ram_port_arbiter_if.sv
// Requester-side bundle of the RAM port arbiter: two write and two read
// requesters with valid/ready handshakes plus the shared read-return bus.
interface ram_port_arbiter_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 8
);
    logic              w0_valid;
    logic [ADDR_W-1:0] w0_addr;
    logic [DATA_W-1:0] w0_data;
    logic              w0_ready;
    logic              w1_valid;
    logic [ADDR_W-1:0] w1_addr;
    logic [DATA_W-1:0] w1_data;
    logic              w1_ready;

    logic              r0_valid;
    logic [ADDR_W-1:0] r0_addr;
    logic              r0_ready;
    logic              r0_rvalid;
    logic              r1_valid;
    logic [ADDR_W-1:0] r1_addr;
    logic              r1_ready;
    logic              r1_rvalid;
    logic [DATA_W-1:0] rdata;

    modport master (
        output w0_valid, w0_addr, w0_data, input w0_ready,
        output w1_valid, w1_addr, w1_data, input w1_ready,
        output r0_valid, r0_addr, input r0_ready, input r0_rvalid,
        output r1_valid, r1_addr, input r1_ready, input r1_rvalid,
        input  rdata
    );

    modport slave (
        input  w0_valid, w0_addr, w0_data, output w0_ready,
        input  w1_valid, w1_addr, w1_data, output w1_ready,
        input  r0_valid, r0_addr, output r0_ready, output r0_rvalid,
        input  r1_valid, r1_addr, output r1_ready, output r1_rvalid,
        output rdata
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// Shares one simple dual-port RAM between two requesters using independent
// round-robin arbiters on the write and read ports, with tagged read return.
module ram_port_arbiter #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 2
) (
    input  logic              clk1,
    input  logic              reset,
    ram_port_arbiter_if.slave bus,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr_in,
    output logic [DATA_W-1:0] ram_d,
    output logic [ADDR_W-1:0] ram_addr_out,
    input  logic [DATA_W-1:0] ram_q
);

    // Round-robin pick: bit 0 grants requester 0, bit 1 grants requester 1.
    // ptr selects who wins when both are asking.
    function automatic logic [1:0] rr_pick(input logic v0, input logic v1, input logic ptr);
        logic [1:0] g;
        case ({v1, v0})
            2'b01:   g = 2'b01;
            2'b10:   g = 2'b10;
            2'b11:   g = ptr ? 2'b10 : 2'b01;
            default: g = 2'b00;
        endcase
        return g;
    endfunction

    logic [1:0]        wgnt_s;
    logic [1:0]        rgnt_s;
    logic              w_ptr_r;
    logic              r_ptr_r;
    logic [RD_LAT:0]   tag_vld_r;
    logic [RD_LAT:0]   tag_id_r;
    logic              r0_rvalid_r;
    logic              r1_rvalid_r;
    logic [DATA_W-1:0] rdata_r;

    // Grant decode for both RAM ports from the current valids and pointers.
    always_comb begin
        wgnt_s = rr_pick(bus.w0_valid, bus.w1_valid, w_ptr_r);
        rgnt_s = rr_pick(bus.r0_valid, bus.r1_valid, r_ptr_r);
    end

    assign bus.w0_ready  = wgnt_s[0];
    assign bus.w1_ready  = wgnt_s[1];
    assign bus.r0_ready  = rgnt_s[0];
    assign bus.r1_ready  = rgnt_s[1];
    assign bus.r0_rvalid = r0_rvalid_r;
    assign bus.r1_rvalid = r1_rvalid_r;
    assign bus.rdata     = rdata_r;

    // Write port: register the granted request towards the RAM, rotate pointer.
    always_ff @(posedge clk1 or posedge reset) begin
        if (reset) begin
            ram_we      <= 1'b0;
            ram_addr_in <= {ADDR_W{1'b0}};
            ram_d       <= {DATA_W{1'b0}};
            w_ptr_r     <= 1'b0;
        end else begin
            ram_we <= |wgnt_s;
            if (wgnt_s[0]) begin
                ram_addr_in <= bus.w0_addr;
                ram_d       <= bus.w0_data;
                w_ptr_r     <= 1'b1;
            end else if (wgnt_s[1]) begin
                ram_addr_in <= bus.w1_addr;
                ram_d       <= bus.w1_data;
                w_ptr_r     <= 1'b0;
            end
        end
    end

    // Read port: register the granted address, rotate pointer.
    always_ff @(posedge clk1 or posedge reset) begin
        if (reset) begin
            ram_addr_out <= {ADDR_W{1'b0}};
            r_ptr_r      <= 1'b0;
        end else begin
            if (rgnt_s[0]) begin
                ram_addr_out <= bus.r0_addr;
                r_ptr_r      <= 1'b1;
            end else if (rgnt_s[1]) begin
                ram_addr_out <= bus.r1_addr;
                r_ptr_r      <= 1'b0;
            end
        end
    end

    // Tag pipe mirrors the address register plus RAM latency; the last stage
    // drives the strobe together with a registered copy of ram_q, so no
    // combinational path exists from ram_q to any output.
    always_ff @(posedge clk1 or posedge reset) begin
        if (reset) begin
            tag_vld_r   <= {(RD_LAT+1){1'b0}};
            tag_id_r    <= {(RD_LAT+1){1'b0}};
            r0_rvalid_r <= 1'b0;
            r1_rvalid_r <= 1'b0;
            rdata_r     <= {DATA_W{1'b0}};
        end else begin
            tag_vld_r   <= {tag_vld_r[RD_LAT-1:0], |rgnt_s};
            tag_id_r    <= {tag_id_r[RD_LAT-1:0], rgnt_s[1]};
            r0_rvalid_r <= tag_vld_r[RD_LAT] & ~tag_id_r[RD_LAT];
            r1_rvalid_r <= tag_vld_r[RD_LAT] &  tag_id_r[RD_LAT];
            rdata_r     <= ram_q;
        end
    end

endmodule
